// File: rtl/compl_pkg.sv
// Shared mode codes and FSM state encoding for the serial complement unit.
package compl_pkg;

   localparam logic [1:0] MODE_NOT  = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;
   localparam logic [1:0] MODE_PASS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/compl_digit_slice.sv
// One DIGIT-wide slice: optional inversion followed by an add of the incoming carry.
module compl_digit_slice #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] d,
   input  logic             inv,
   input  logic             cin,
   output logic [DIGIT-1:0] q,
   output logic             cout
);

   logic [DIGIT:0] sum;

   always_comb begin
      sum = {1'b0, (inv ? ~d : d)} + {{DIGIT{1'b0}}, cin};
   end

   assign q    = sum[DIGIT-1:0];
   assign cout = sum[DIGIT];

endmodule

// File: rtl/serial_complement_unit.sv
// Digit-serial NOT/NEG/ABS/PASS engine with valid/ready handshakes on both sides.
// Define COMPL_OVF_EN to add the out_ovf port and most-negative-operand detection.
module serial_complement_unit
   import compl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero
`ifdef COMPL_OVF_EN
   ,output logic            out_ovf
`endif
);

   localparam int             NDIG = WIDTH / DIGIT;
   localparam int             CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

   state_e           stateQ, stateD;
   logic [CW-1:0]    cntQ, cntD;
   logic             carryQ, carryD;
   logic             negSelQ, negSelD;
   logic [1:0]       modeQ, modeD;
   logic [WIDTH-1:0] opQ, opD;
   logic [WIDTH-1:0] accQ, accD;
   logic [WIDTH-1:0] outDataQ, outDataD;
   logic             outZeroQ, outZeroD;
`ifdef COMPL_OVF_EN
   logic             ovfArmQ, ovfArmD;
   logic             outOvfQ, outOvfD;
`endif

   logic             sliceInv;
   logic             sliceCin;
   logic [DIGIT-1:0] sliceOut;
   logic             sliceCout;
   logic [WIDTH-1:0] accShift;
   logic             newNegSel;

   // The operand shifts right so the active digit always sits at the bottom.
   compl_digit_slice #(.DIGIT(DIGIT)) uSlice (
      .d    (opQ[DIGIT-1:0]),
      .inv  (sliceInv),
      .cin  (sliceCin),
      .q    (sliceOut),
      .cout (sliceCout)
   );

   assign sliceInv  = (modeQ == MODE_NOT) | negSelQ;
   assign sliceCin  = negSelQ & carryQ;
   assign accShift  = WIDTH'({sliceOut, accQ} >> DIGIT);
   assign newNegSel = (in_mode == MODE_NEG) | ((in_mode == MODE_ABS) & in_data[WIDTH-1]);

   // Next-state and datapath updates; every register holds unless its state acts on it.
   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      carryD   = carryQ;
      negSelD  = negSelQ;
      modeD    = modeQ;
      opD      = opQ;
      accD     = accQ;
      outDataD = outDataQ;
      outZeroD = outZeroQ;
`ifdef COMPL_OVF_EN
      ovfArmD  = ovfArmQ;
      outOvfD  = outOvfQ;
`endif
      case (stateQ)
         ST_IDLE: begin
            if (in_valid) begin
               opD     = in_data;
               modeD   = in_mode;
               cntD    = '0;
               negSelD = newNegSel;
               carryD  = newNegSel;
`ifdef COMPL_OVF_EN
               ovfArmD = newNegSel & (in_data == {1'b1, {(WIDTH-1){1'b0}}});
`endif
               stateD  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            opD    = opQ >> DIGIT;
            accD   = accShift;
            carryD = sliceCout;
            cntD   = cntQ + 1'b1;
            if (cntQ == LAST) begin
               outDataD = accShift;
               outZeroD = (accShift == '0);
`ifdef COMPL_OVF_EN
               outOvfD  = ovfArmQ;
`endif
               stateD   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
`ifdef COMPL_OVF_EN
               outOvfD = 1'b0;
`endif
               stateD  = ST_IDLE;
            end
         end
         default: stateD = ST_IDLE;
      endcase
   end

   // Synchronous reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= ST_IDLE;
         cntQ     <= '0;
         carryQ   <= 1'b0;
         negSelQ  <= 1'b0;
         modeQ    <= MODE_NOT;
         opQ      <= '0;
         accQ     <= '0;
         outDataQ <= '0;
         outZeroQ <= 1'b0;
`ifdef COMPL_OVF_EN
         ovfArmQ  <= 1'b0;
         outOvfQ  <= 1'b0;
`endif
      end else begin
         stateQ   <= stateD;
         cntQ     <= cntD;
         carryQ   <= carryD;
         negSelQ  <= negSelD;
         modeQ    <= modeD;
         opQ      <= opD;
         accQ     <= accD;
         outDataQ <= outDataD;
         outZeroQ <= outZeroD;
`ifdef COMPL_OVF_EN
         ovfArmQ  <= ovfArmD;
         outOvfQ  <= outOvfD;
`endif
      end
   end

   assign in_ready  = (stateQ == ST_IDLE);
   assign out_valid = (stateQ == ST_DONE);
   assign out_data  = outDataQ;
   assign out_zero  = outZeroQ;
`ifdef COMPL_OVF_EN
   assign out_ovf   = outOvfQ;
`endif

endmodule

// File: tb/tb_serial_complement_unit.sv
// Directed bench: an 8-bit/4-bit-digit instance driven from a vector table plus
// hand-written corner sequences, and a 32-bit/8-bit-digit instance for latency/throughput.
module tb_serial_complement_unit;
   import compl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        v8InValid = 1'b0;
   logic        v8InReady;
   logic [7:0]  v8InData = '0;
   logic [1:0]  v8InMode = MODE_NOT;
   logic        v8OutValid;
   logic        v8OutReady = 1'b0;
   logic [7:0]  v8OutData;
   logic        v8OutZero;
   logic        v8OutOvf;

   logic        v32InValid = 1'b0;
   logic        v32InReady;
   logic [31:0] v32InData = '0;
   logic [1:0]  v32InMode = MODE_NOT;
   logic        v32OutValid;
   logic        v32OutReady = 1'b0;
   logic [31:0] v32OutData;
   logic        v32OutZero;
   logic        v32OutOvf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] data;
      logic [7:0] expData;
      logic       expZero;
      logic       expOvf;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   serial_complement_unit #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v8InValid),
      .in_ready  (v8InReady),
      .in_data   (v8InData),
      .in_mode   (v8InMode),
      .out_valid (v8OutValid),
      .out_ready (v8OutReady),
      .out_data  (v8OutData),
      .out_zero  (v8OutZero)
`ifdef COMPL_OVF_EN
      ,.out_ovf  (v8OutOvf)
`endif
   );

   serial_complement_unit #(.WIDTH(32), .DIGIT(8)) dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v32InValid),
      .in_ready  (v32InReady),
      .in_data   (v32InData),
      .in_mode   (v32InMode),
      .out_valid (v32OutValid),
      .out_ready (v32OutReady),
      .out_data  (v32OutData),
      .out_zero  (v32OutZero)
`ifdef COMPL_OVF_EN
      ,.out_ovf  (v32OutOvf)
`endif
   );

`ifndef COMPL_OVF_EN
   assign v8OutOvf  = 1'b0;
   assign v32OutOvf = 1'b0;
`endif

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer one operand to the 8-bit unit and wait (bounded) until its result is valid.
   task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] data, output int lat);
      checkOutput("in_ready before accept", 32'(v8InReady), 32'd1);
      v8InMode  = mode;
      v8InData  = data;
      v8InValid = 1'b1;
      @(posedge clk); #1;
      v8InValid = 1'b0;
      v8InData  = 8'hC3;
      lat = 0;
      while (!v8OutValid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Consume the pending 8-bit result and confirm the unit goes back to idle.
   task automatic takeResult8();
      v8OutReady = 1'b1;
      @(posedge clk); #1;
      v8OutReady = 1'b0;
      checkOutput("out_valid drops after take", 32'(v8OutValid), 32'd0);
      checkOutput("in_ready after take", 32'(v8InReady), 32'd1);
   endtask

   initial begin
      int lat;
      int prev;
      int nres;
      bit sawValid;

      vecs[0]  = '{MODE_NOT,  8'h5A, 8'hA5, 1'b0, 1'b0};
      vecs[1]  = '{MODE_NEG,  8'h01, 8'hFF, 1'b0, 1'b0};
      vecs[2]  = '{MODE_NEG,  8'h00, 8'h00, 1'b1, 1'b0};
      vecs[3]  = '{MODE_NEG,  8'h10, 8'hF0, 1'b0, 1'b0};
      vecs[4]  = '{MODE_ABS,  8'hFB, 8'h05, 1'b0, 1'b0};
      vecs[5]  = '{MODE_ABS,  8'h05, 8'h05, 1'b0, 1'b0};
      vecs[6]  = '{MODE_ABS,  8'h80, 8'h80, 1'b0, 1'b1};
      vecs[7]  = '{MODE_PASS, 8'h3C, 8'h3C, 1'b0, 1'b0};
      vecs[8]  = '{MODE_NEG,  8'h80, 8'h80, 1'b0, 1'b1};
      vecs[9]  = '{MODE_NOT,  8'hFF, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{MODE_NOT,  8'h80, 8'h7F, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      checkOutput("reset in_ready", 32'(v8InReady), 32'd1);
      checkOutput("reset out_valid", 32'(v8OutValid), 32'd0);
      checkOutput("reset out_data", 32'(v8OutData), 32'd0);
      checkOutput("reset out_zero", 32'(v8OutZero), 32'd0);
`ifdef COMPL_OVF_EN
      checkOutput("reset out_ovf", 32'(v8OutOvf), 32'd0);
`endif

      // Table-driven functional vectors.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].data, lat);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
         checkOutput($sformatf("vec%0d out_data", i), 32'(v8OutData), 32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d out_zero", i), 32'(v8OutZero), 32'(vecs[i].expZero));
`ifdef COMPL_OVF_EN
         checkOutput($sformatf("vec%0d out_ovf", i), 32'(v8OutOvf), 32'(vecs[i].expOvf));
`endif
         takeResult8();
      end

      // Backpressure: result held for 5 cycles while stray in_valid pulses are ignored.
      applyStimulus(MODE_NEG, 8'h10, lat);
      checkOutput("bp latency", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
         v8InValid = c[0];
         v8InData  = 8'h11 + 8'(c);
         v8InMode  = MODE_PASS;
         @(posedge clk); #1;
         checkOutput("bp out_valid held", 32'(v8OutValid), 32'd1);
         checkOutput("bp out_data held", 32'(v8OutData), 32'hF0);
         checkOutput("bp in_ready low", 32'(v8InReady), 32'd0);
      end
      v8InValid = 1'b0;
      takeResult8();
      sawValid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (v8OutValid) sawValid = 1'b1;
      end
      checkOutput("bp no spurious op", 32'(sawValid), 32'd0);

      // Reset during the second BUSY cycle abandons the operation.
      checkOutput("rst pre in_ready", 32'(v8InReady), 32'd1);
      v8InMode  = MODE_NEG;
      v8InData  = 8'h33;
      v8InValid = 1'b1;
      @(posedge clk); #1;
      v8InValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst pre busy", 32'(v8InReady), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst in_ready", 32'(v8InReady), 32'd1);
      checkOutput("rst out_valid", 32'(v8OutValid), 32'd0);
      checkOutput("rst out_data", 32'(v8OutData), 32'd0);
      sawValid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (v8OutValid) sawValid = 1'b1;
      end
      checkOutput("rst no result emitted", 32'(sawValid), 32'd0);

      // 32-bit instance: PASS latency of four digits.
      checkOutput("w32 in_ready", 32'(v32InReady), 32'd1);
      v32InMode  = MODE_PASS;
      v32InData  = 32'hDEADBEEF;
      v32InValid = 1'b1;
      @(posedge clk); #1;
      v32InValid = 1'b0;
      lat = 0;
      while (!v32OutValid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("w32 pass latency", 32'(lat), 32'd4);
      checkOutput("w32 pass data", v32OutData, 32'hDEADBEEF);
      checkOutput("w32 pass zero", 32'(v32OutZero), 32'd0);
      v32OutReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("w32 out_valid drops", 32'(v32OutValid), 32'd0);

      // Back-to-back NEG operations with the consumer always ready.
      v32InMode  = MODE_NEG;
      v32InData  = 32'hDEADBEEF;
      v32InValid = 1'b1;
      prev = -1;
      nres = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (v32OutValid) begin
            checkOutput("b2b data", v32OutData, 32'h21524111);
`ifdef COMPL_OVF_EN
            checkOutput("b2b ovf", 32'(v32OutOvf), 32'd0);
`endif
            if (prev >= 0) checkOutput("b2b period", 32'(c - prev), 32'd6);
            prev = c;
            nres++;
         end
      end
      v32InValid  = 1'b0;
      v32OutReady = 1'b0;
      checkOutput("b2b result count", 32'(nres >= 6), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
